// File: rtl/bcd_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_counter
// Purpose  : Cascaded multi-digit BCD up/down counter with synchronous load,
//            enable and wrap (carry/borrow) pulse, driving a time-multiplexed
//            8-position common-anode seven-segment display. All timing comes
//            from clock-enable prescalers on clk_in; no derived clocks.
// Params   : DIGITS   - BCD digits counted/displayed (1..8)
//            TICK_DIV - clk_in cycles per count tick (>= 2)
//            SCAN_DIV - clk_in cycles per display position (>= 2)
// Ports    : clk_in   in   system clock, rising edge
//            reset    in   synchronous active-high reset
//            en       in   count enable, sampled on tick cycles
//            up       in   1 = count up, 0 = count down
//            load     in   synchronous load strobe (beats a tick)
//            load_val in   BCD load value, digit 0 in [3:0]; digits >9 load 0
//            count    out  registered BCD count, digit 0 in [3:0]
//            carry    out  one-cycle pulse when the wrapped value appears
//            AN       out  anode enables, active low, one-hot
//            SEG      out  {dp,g,f,e,d,c,b,a}, active low, dp always 1
// Options  : `define LEADING_ZERO_BLANK_EN blanks leading zero digits
//            (digit 0 never blanked); count/carry unaffected.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_scan_counter #(
  parameter int DIGITS   = 8,
  parameter int TICK_DIV = 100_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                carry,
  output logic [7:0]          AN,
  output logic [7:0]          SEG
);

  localparam int                  c_TICK_W    = $clog2(TICK_DIV);
  localparam int                  c_SCAN_W    = $clog2(SCAN_DIV);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
  localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);
  localparam logic [2:0]          c_IDX_LAST  = 3'(DIGITS - 1);

  logic [c_TICK_W-1:0] r_tick_cnt;
  logic [c_SCAN_W-1:0] r_scan_cnt;
  logic [2:0]          r_scan_idx;

  logic                w_tick;
  logic                w_scan_step;
  logic [4*DIGITS-1:0] w_load_clean;
  logic [4*DIGITS-1:0] w_count_step;
  logic                w_chain;
  logic                w_wrap;
  logic [3:0]          w_digit;
  logic [7:0]          w_seg;
  logic [7:0]          w_an;
  logic                w_blank;

  assign w_tick      = (r_tick_cnt == c_TICK_LAST);
  assign w_scan_step = (r_scan_cnt == c_SCAN_LAST);

  // --------------------------------------------------------------------------
  // Count-tick prescaler: 0..TICK_DIV-1, tick on the last value
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Load sanitising: any non-BCD digit is loaded as 0, so the counter can
  // never hold a digit above 9.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_load_clean
      assign w_load_clean[4*gi +: 4] =
        (load_val[4*gi +: 4] > 4'd9) ? 4'd0 : load_val[4*gi +: 4];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Ripple step: w_chain is 1 while every lower digit is at its rollover
  // value (9 going up, 0 going down), so it both enables each digit's step
  // and, after the last digit, flags the whole-counter wrap.
  // --------------------------------------------------------------------------
  always_comb begin
    w_count_step = count;
    w_chain      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_chain) begin
        if (up) begin
          w_count_step[4*i +: 4] = (count[4*i +: 4] == 4'd9) ? 4'd0
                                                              : count[4*i +: 4] + 4'd1;
        end else begin
          w_count_step[4*i +: 4] = (count[4*i +: 4] == 4'd0) ? 4'd9
                                                              : count[4*i +: 4] - 4'd1;
        end
      end
      w_chain = w_chain & (up ? (count[4*i +: 4] == 4'd9)
                              : (count[4*i +: 4] == 4'd0));
    end
    w_wrap = w_chain;
  end

  // Priority: reset > load > (tick & en) > hold. carry is cleared on every
  // non-wrapping cycle so it lasts exactly one cycle.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      count <= '0;
      carry <= 1'b0;
    end else if (load) begin
      count <= w_load_clean;
      carry <= 1'b0;
    end else if (w_tick && en) begin
      count <= w_count_step;
      carry <= w_wrap;
    end else begin
      carry <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Scan prescaler and display position
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_scan_idx <= 3'd0;
    end else if (w_scan_step) begin
      r_scan_cnt <= '0;
      r_scan_idx <= (r_scan_idx == c_IDX_LAST) ? 3'd0 : r_scan_idx + 3'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + c_SCAN_W'(1);
    end
  end

  // Digit mux; r_scan_idx never exceeds DIGITS-1
  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scan_idx == 3'(i)) begin
        w_digit = count[4*i +: 4];
      end
    end
  end

  always_comb begin
    case (w_digit)
      4'd0:    w_seg = 8'hC0;
      4'd1:    w_seg = 8'hF9;
      4'd2:    w_seg = 8'hA4;
      4'd3:    w_seg = 8'hB0;
      4'd4:    w_seg = 8'h99;
      4'd5:    w_seg = 8'h92;
      4'd6:    w_seg = 8'h82;
      4'd7:    w_seg = 8'hF8;
      4'd8:    w_seg = 8'h80;
      4'd9:    w_seg = 8'h90;
      default: w_seg = 8'hFF;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // w_lz[i] = digit i and every digit above it are zero
  logic [DIGITS-1:0] w_lz;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lz
      if (gi == DIGITS - 1) begin : g_lz_top
        assign w_lz[gi] = (count[4*gi +: 4] == 4'd0);
      end else begin : g_lz_mid
        assign w_lz[gi] = w_lz[gi+1] & (count[4*gi +: 4] == 4'd0);
      end
    end
  endgenerate

  always_comb begin
    w_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((r_scan_idx == 3'(i)) && (i != 0)) begin
        w_blank = w_lz[i];
      end
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_an             = 8'hFF;
    w_an[r_scan_idx] = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      AN  <= 8'hFF;
      SEG <= 8'hFF;
    end else begin
      AN  <= w_an;
      SEG <= w_blank ? 8'hFF : w_seg;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_scan_counter
// Purpose  : Self-checking bench for bcd_scan_counter. Four instances
//            (DIGITS = 1..4, TICK_DIV=4, SCAN_DIV=2) share stimulus; an
//            integer-arithmetic reference model predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_counter;

  localparam int TICK = 4;
  localparam int SCAN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ld, en, up;
  logic [15:0] lv;

  logic [3:0]  cnt1;
  logic [7:0]  cnt2;
  logic [11:0] cnt3;
  logic [15:0] cnt4;
  logic        cy_v  [4];
  logic [7:0]  an_v  [4];
  logic [7:0]  seg_v [4];
  logic [15:0] cnt_a [4];

  always_comb begin
    cnt_a[0] = {12'h000, cnt1};
    cnt_a[1] = {8'h00, cnt2};
    cnt_a[2] = {4'h0, cnt3};
    cnt_a[3] = cnt4;
  end

  bcd_scan_counter #(.DIGITS(1), .TICK_DIV(TICK), .SCAN_DIV(SCAN)) u_d1 (
    .clk_in(clk), .reset(rst), .en(en), .up(up), .load(ld), .load_val(lv[3:0]),
    .count(cnt1), .carry(cy_v[0]), .AN(an_v[0]), .SEG(seg_v[0]));
  bcd_scan_counter #(.DIGITS(2), .TICK_DIV(TICK), .SCAN_DIV(SCAN)) u_d2 (
    .clk_in(clk), .reset(rst), .en(en), .up(up), .load(ld), .load_val(lv[7:0]),
    .count(cnt2), .carry(cy_v[1]), .AN(an_v[1]), .SEG(seg_v[1]));
  bcd_scan_counter #(.DIGITS(3), .TICK_DIV(TICK), .SCAN_DIV(SCAN)) u_d3 (
    .clk_in(clk), .reset(rst), .en(en), .up(up), .load(ld), .load_val(lv[11:0]),
    .count(cnt3), .carry(cy_v[2]), .AN(an_v[2]), .SEG(seg_v[2]));
  bcd_scan_counter #(.DIGITS(4), .TICK_DIV(TICK), .SCAN_DIV(SCAN)) u_d4 (
    .clk_in(clk), .reset(rst), .en(en), .up(up), .load(ld), .load_val(lv),
    .count(cnt4), .carry(cy_v[3]), .AN(an_v[3]), .SEG(seg_v[3]));

  int n_vec = 0;
  int n_bad = 0;

  int          dig_n   [4] = '{1, 2, 3, 4};
  logic [7:0]  seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Reference model state: counter value as an integer, cycles since reset
  int         m_k;
  int         m_val [4];
  logic       m_cy  [4];
  logic [7:0] m_an  [4];
  logic [7:0] m_seg [4];

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int clean_val(input logic [15:0] v, input int d);
    int r = 0;
    for (int p = 0; p < d; p++) begin
      int nib = int'((v >> (4 * p)) & 16'h000F);
      if (nib > 9) nib = 0;
      r = r + nib * pow10(p);
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v, input int d);
    logic [15:0] r = '0;
    for (int p = 0; p < d; p++) r = r | (16'((v / pow10(p)) % 10) << (4 * p));
    return r;
  endfunction

  task automatic model_step(input logic r, input logic l, input logic e,
                            input logic u, input logic [15:0] v);
    for (int i = 0; i < 4; i++) begin
      int d   = dig_n[i];
      int m   = pow10(d);
      int pos;
      if (r) begin
        m_val[i] = 0;
        m_cy[i]  = 1'b0;
        m_an[i]  = 8'hFF;
        m_seg[i] = 8'hFF;
      end else begin
        pos      = (m_k / SCAN) % d;
        m_an[i]  = ~(8'd1 << pos);
        m_seg[i] = seg_tbl[(m_val[i] / pow10(pos)) % 10];
`ifdef LEADING_ZERO_BLANK_EN
        if (pos >= 1 && m_val[i] < pow10(pos)) m_seg[i] = 8'hFF;
`endif
        if (l) begin
          m_val[i] = clean_val(v, d);
          m_cy[i]  = 1'b0;
        end else if ((m_k % TICK) == TICK - 1 && e) begin
          if (u) begin
            m_cy[i]  = (m_val[i] == m - 1);
            m_val[i] = (m_val[i] + 1) % m;
          end else begin
            m_cy[i]  = (m_val[i] == 0);
            m_val[i] = (m_val[i] + m - 1) % m;
          end
        end else begin
          m_cy[i] = 1'b0;
        end
      end
    end
    m_k = r ? 0 : m_k + 1;
  endtask

  task automatic check(input string nm, input int inst,
                       input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s D=%0d k=%0d act=%h exp=%h", nm, dig_n[inst], m_k, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, step the model, sample at the next
  // falling edge, compare all instances against the model.
  task automatic do_cycle(input logic r, input logic l, input logic e,
                          input logic u, input logic [15:0] v);
    rst = r; ld = l; en = e; up = u; lv = v;
    model_step(r, l, e, u, v);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("count", i, cnt_a[i], to_bcd(m_val[i], dig_n[i]));
      check("carry", i, {15'h0, cy_v[i]}, {15'h0, m_cy[i]});
      check("an",    i, {8'h00, an_v[i]}, {8'h00, m_an[i]});
      check("seg",   i, {8'h00, seg_v[i]}, {8'h00, m_seg[i]});
    end
  endtask

  typedef struct {
    logic        r, l, e, u;
    logic [15:0] v;
    logic [7:0]  exp_cnt;
    logic        exp_cy;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic l, input logic e,
                              input logic u, input logic [15:0] v,
                              input logic [7:0] c, input logic y);
    vec_t t;
    t.r = r; t.l = l; t.e = e; t.u = u; t.v = v; t.exp_cnt = c; t.exp_cy = y;
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[$];
    logic [7:0] sc_an  [8] = '{8'hFE, 8'hFD, 8'hFD, 8'hFB, 8'hFB, 8'hFE, 8'hFE, 8'hFD};
    logic [7:0] sc_seg [8] = '{8'h92, 8'hC0, 8'hC0, 8'hB0, 8'hB0, 8'h92, 8'h92, 8'hC0};
    logic [7:0] bl_an  [8] = '{8'hFE, 8'hFD, 8'hFD, 8'hFB, 8'hFB, 8'hF7, 8'hF7, 8'hFE};
    logic [7:0] bl_hi;
    logic [15:0] rv;

    m_k = 0;
    rst = 1'b1; ld = 1'b0; en = 1'b0; up = 1'b0; lv = '0;

    // DIGITS=2 vector table; comment = prescaler phase before the edge
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 8'h00, 0)); // reset
    tbl.push_back(mk(0, 1, 0, 0, 16'h0098, 8'h98, 0)); // k0 load 98
    tbl.push_back(mk(0, 0, 1, 1, 16'h0000, 8'h98, 0)); // k1
    tbl.push_back(mk(0, 0, 1, 1, 16'h0000, 8'h98, 0)); // k2
    tbl.push_back(mk(0, 0, 1, 1, 16'h0000, 8'h99, 0)); // k3 tick
    tbl.push_back(mk(0, 0, 1, 1, 16'h0000, 8'h99, 0)); // k4
    tbl.push_back(mk(0, 0, 1, 1, 16'h0000, 8'h99, 0)); // k5
    tbl.push_back(mk(0, 0, 1, 1, 16'h0000, 8'h99, 0)); // k6
    tbl.push_back(mk(0, 0, 1, 1, 16'h0000, 8'h00, 1)); // k7 tick, wrap
    tbl.push_back(mk(0, 0, 1, 1, 16'h0000, 8'h00, 0)); // k8
    tbl.push_back(mk(0, 0, 1, 1, 16'h0000, 8'h00, 0)); // k9
    tbl.push_back(mk(0, 0, 1, 1, 16'h0000, 8'h00, 0)); // k10
    tbl.push_back(mk(0, 1, 1, 1, 16'h001A, 8'h10, 0)); // k11 tick+load 1A
    tbl.push_back(mk(0, 1, 1, 0, 16'h0001, 8'h01, 0)); // k12 load 01
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 8'h01, 0)); // k13
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 8'h01, 0)); // k14
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 8'h00, 0)); // k15 tick
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 8'h00, 0)); // k16
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 8'h00, 0)); // k17
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 8'h00, 0)); // k18
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 8'h99, 1)); // k19 tick, borrow
    tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 8'h99, 0)); // k20
    for (int i = 0; i < 3 * TICK; i++)                 // en=0 across 3 ticks
      tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 8'h99, 0));

    // Reset held 3 cycles, then first released cycle shows digit 0
    for (int i = 0; i < 3; i++) begin
      do_cycle(1, 0, 0, 0, 16'h0000);
      check("rst_an",    1, {8'h00, an_v[1]},  16'h00FF);
      check("rst_seg",   1, {8'h00, seg_v[1]}, 16'h00FF);
      check("rst_count", 1, cnt_a[1],          16'h0000);
    end
    do_cycle(0, 0, 0, 0, 16'h0000);
    check("post_rst_an",  1, {8'h00, an_v[1]},  16'h00FE);
    check("post_rst_seg", 1, {8'h00, seg_v[1]}, 16'h00C0);
    check("post_rst_an1", 0, {8'h00, an_v[0]},  16'h00FE);

    // Table-driven DIGITS=2 counting/load sequence
    foreach (tbl[j]) begin
      do_cycle(tbl[j].r, tbl[j].l, tbl[j].e, tbl[j].u, tbl[j].v);
      check("tbl_count", 1, cnt_a[1], {8'h00, tbl[j].exp_cnt});
      check("tbl_carry", 1, {15'h0, cy_v[1]}, {15'h0, tbl[j].exp_cy});
    end

    // Scan order and digit decode, DIGITS=3, count 305
    do_cycle(1, 0, 0, 0, 16'h0000);
    do_cycle(0, 1, 0, 0, 16'h0305);
    for (int j = 0; j < 8; j++) begin
      do_cycle(0, 0, 0, 0, 16'h0000);
      check("scan_an",    2, {8'h00, an_v[2]},  {8'h00, sc_an[j]});
      check("scan_an_hi", 2, {11'h0, an_v[2][7:3]}, 16'h001F);
      check("scan_seg",   2, {8'h00, seg_v[2]}, {8'h00, sc_seg[j]});
    end

    // Leading-zero handling, DIGITS=4, count 0007
`ifdef LEADING_ZERO_BLANK_EN
    bl_hi = 8'hFF;
`else
    bl_hi = 8'hC0;
`endif
    do_cycle(1, 0, 0, 0, 16'h0000);
    do_cycle(0, 1, 0, 0, 16'h0007);
    for (int j = 0; j < 8; j++) begin
      do_cycle(0, 0, 0, 0, 16'h0000);
      check("blank_an",  3, {8'h00, an_v[3]}, {8'h00, bl_an[j]});
      check("blank_seg", 3, {8'h00, seg_v[3]},
            {8'h00, (bl_an[j] == 8'hFE) ? 8'hF8 : bl_hi});
    end

    // Randomised run against the model, biased toward wrap-adjacent loads
    for (int j = 0; j < 3000; j++) begin
      case ($urandom_range(0, 3))
        0:       rv = 16'($urandom);
        1:       rv = 16'h9999;
        2:       rv = 16'h0000;
        default: rv = {4'($urandom_range(8, 9)), 4'($urandom_range(8, 9)),
                       4'($urandom_range(0, 1)), 4'($urandom_range(8, 9))};
      endcase
      do_cycle(($urandom_range(0, 299) == 0),
               ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)),
               rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
